// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: resolves RV32I branches/jumps in EX, serves a 2-bit counter
// prediction table to IF, and keeps saturating branch/mispredict counters.
module branch_resolve_predict #(
   parameter int ENTRIES    = 64,
   parameter int PC_WIDTH   = 32,
   parameter int CNT_WIDTH  = 16,
   parameter bit PREDICT_EN = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [PC_WIDTH-1:0]  if_pc,
   output logic                 if_pred_taken,
   input  logic                 ex_valid,
   input  logic [PC_WIDTH-1:0]  ex_pc,
   input  logic                 ex_jump,
   input  logic                 ex_branch,
   input  logic [2:0]           ex_funct3,
   input  logic                 ex_pred_taken,
   input  logic                 alu_zero,
   input  logic                 alu_lt,
   input  logic                 alu_ltu,
   output logic                 pc_src,
   output logic                 mispredict,
   output logic                 illegal_cond,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);
   localparam int IW = $clog2(ENTRIES);
   logic [1:0] tbl [ENTRIES];
   logic [IW-1:0] if_idx, ex_idx;
   logic [1:0] cur, nxt;
   logic cond, taken, is_branch, upd;
   logic unused_pc;
   assign if_idx = if_pc[IW+1:2];
   assign ex_idx = ex_pc[IW+1:2];
   assign unused_pc = ^{if_pc[PC_WIDTH-1:IW+2], if_pc[1:0], ex_pc[PC_WIDTH-1:IW+2], ex_pc[1:0]};
   always_comb begin
      cond          = ex_funct3[2:1] == 2'b00 ? alu_zero : ex_funct3[2:1] == 2'b10 ? alu_lt : alu_ltu;
      taken         = ex_funct3[2:1] != 2'b01 && (cond ^ ex_funct3[0]);
      illegal_cond  = ex_valid && ex_branch && ex_funct3[2:1] == 2'b01;
      is_branch     = ex_valid && ex_branch && !ex_jump;
      pc_src        = ex_valid && (ex_jump || (ex_branch && taken));
      mispredict    = ex_valid && (ex_jump || ex_branch) && (pc_src != ex_pred_taken);
      upd           = PREDICT_EN && is_branch && !illegal_cond;
      cur           = tbl[ex_idx];
      nxt           = taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
      if_pred_taken = PREDICT_EN ? tbl[if_idx][1] : 1'b0;
   end
   // Reset wins over a same-cycle update; all entries return to weak-not-taken at once.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
      end else if (upd) begin
         tbl[ex_idx] <= nxt;
      end
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (is_branch && !(&branch_count)) branch_count <= branch_count + 1'b1;
         if (mispredict && !(&mispredict_count)) mispredict_count <= mispredict_count + 1'b1;
      end
   end
endmodule
